// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and constants for the memory bridge.
//   state_e   - bridge FSM states
//   wentry_t  - posted-write buffer entry {addr, data}
//   MAX_WAIT  - largest wait-state count the 3-bit strobe counter can hold
//   wait_load - counter preload for a given wait-state setting
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_ACC,
    RD_ACC,
    RESP
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wentry_t;

  localparam int unsigned MAX_WAIT = 7;

  // Out-of-range settings saturate at MAX_WAIT.
  function automatic logic [2:0] wait_load(input int unsigned ws);
    if (ws > MAX_WAIT) return 3'(MAX_WAIT);
    return 3'(ws);
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// mem_bridge_if: core-side request/response and Memoria-side bus signals.
//   slave  - the bridge view (takes core requests, drives memory strobes)
//   master - the environment view (core drives requests, memory returns data)
interface mem_bridge_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        wbuf_full;
  logic [31:0] mem_dir;
  logic [31:0] mem_dato;
  logic        mem_rd;
  logic        mem_wd;
  logic [31:0] mem_output;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_output,
    output cpu_ready, cpu_rvalid, cpu_rdata, wbuf_full,
           mem_dir, mem_dato, mem_rd, mem_wd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_output,
    input  cpu_ready, cpu_rvalid, cpu_rdata, wbuf_full,
           mem_dir, mem_dato, mem_rd, mem_wd
  );

endinterface

// File: rtl/mem_bridge_wbuf_fifo.sv
// wbuf_fifo: synchronous FIFO holding posted writes.
//   clk, reset - clock, asynchronous active-high reset (empties the FIFO)
//   push, din  - enqueue din; ignored while full
//   pop        - dequeue head; ignored while empty
//   head       - oldest entry
//   full       - registered, DEPTH entries held
//   empty      - no entries held
module wbuf_fifo
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  wentry_t din,
  output wentry_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  wentry_t         store [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_next;
  logic            do_push;
  logic            do_pop;

  // full is the registered flag, so a pop in the same cycle cannot free a
  // slot for a push that arrives while the buffer is full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign head    = store[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == DEPTH_C);
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: core-to-Memoria access controller.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - mem_bridge_if.slave:
//     cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_ready (combinational) out,
//     cpu_rvalid/cpu_rdata load response, wbuf_full write-buffer status,
//     mem_dir/mem_dato/mem_rd/mem_wd memory strobes, mem_output read data.
// Stores are posted into wbuf_fifo and drained one per IDLE visit; loads are
// only accepted once the buffer is empty, so they always see the newest data.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned WBUF_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_bridge_if.slave  bus
);

  localparam logic [2:0] WAIT_LOAD = wait_load(WAIT_STATES);

  state_e      state;
  logic [2:0]  wait_cnt;
  logic        rd_q;
  logic        wd_q;
  logic        rvalid_q;
  logic [31:0] dir_q;
  logic [31:0] dato_q;
  logic [31:0] rdata_q;

  logic        ready;
  logic        push;
  logic        pop;
  logic        ld_accept;
  logic        fifo_full;
  logic        fifo_empty;
  wentry_t     push_entry;
  wentry_t     head;

  // A load leaves IDLE on its own accepting edge, so "no load outstanding"
  // is covered by requiring IDLE.
  always_comb begin
    ready = 1'b0;
    if (bus.cpu_we) ready = !fifo_full;
    else            ready = fifo_empty && (state == IDLE);
  end

  assign push      = bus.cpu_req && bus.cpu_we && ready;
  assign ld_accept = bus.cpu_req && !bus.cpu_we && ready;
  assign pop       = (state == WR_ACC) && (wait_cnt == 3'd0);

  assign push_entry.addr = bus.cpu_addr;
  assign push_entry.data = bus.cpu_wdata;

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Strobes and bus values are registered on the edge that enters an access,
  // so a load accepted in cycle 0 has mem_rd high from cycle 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rd_q     <= 1'b0;
      wd_q     <= 1'b0;
      rvalid_q <= 1'b0;
      dir_q    <= '0;
      dato_q   <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state    <= WR_ACC;
            wd_q     <= 1'b1;
            dir_q    <= head.addr;
            dato_q   <= head.data;
            wait_cnt <= WAIT_LOAD;
          end else if (ld_accept) begin
            state    <= RD_ACC;
            rd_q     <= 1'b1;
            dir_q    <= bus.cpu_addr;
            wait_cnt <= WAIT_LOAD;
          end
        end
        WR_ACC: begin
          if (wait_cnt == 3'd0) begin
            wd_q  <= 1'b0;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RD_ACC: begin
          if (wait_cnt == 3'd0) begin
            rd_q     <= 1'b0;
            rdata_q  <= bus.mem_output;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready  = ready;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.wbuf_full  = fifo_full;
  assign bus.mem_dir    = dir_q;
  assign bus.mem_dato   = dato_q;
  assign bus.mem_rd     = rd_q;
  assign bus.mem_wd     = wd_q;

endmodule
